// File: rtl/input_debouncer.sv
// Per-channel pad conditioner: 2-flop synchroniser, stability counter, debounced level and
// one-cycle rise/fall strobes. Define INPUT_DEBOUNCER_TOGGLE_EN to add latching tog_out.
module input_debouncer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] tog_out
`endif
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_q, s2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            db_q, db_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;

    // Synchroniser runs regardless of ena so the pads are always tracked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_in;
            s2_q <= s2_d_sync(s1_q);
        end
    end

    function automatic logic [WIDTH-1:0] s2_d_sync(input logic [WIDTH-1:0] v);
        return v;
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        if (ena) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    cnt_d[i]  = '0;
                    db_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    logic [WIDTH-1:0] tog_q;

    // Flips on the same edge that loads the rise strobe, turning a button into a latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_q ^ rise_d;
        end
    end

    assign tog_out = tog_q;
`else
    // Plain debouncer: no latching outputs.
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a sample-window reference model checked every cycle.
module tb_input_debouncer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STABLE = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    logic [WIDTH-1:0] tog_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    input_debouncer #(
        .WIDTH        (WIDTH),
        .CNT_W        (CNT_W),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .raw_in    (raw_in),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        ,
        .tog_out   (tog_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the level flips once the last STABLE enabled synchronised samples all
    // disagree with it. Samples are a history queue, cleared by reset.
    logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0, m_tog = '0;
    logic [WIDTH-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin : model
        logic [WIDTH-1:0] nd, nr, nf;
        bit all_diff;
        if (!rst_n) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_db   <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_tog  <= '0;
            hist.delete();
        end else begin
            nd = m_db;
            nr = '0;
            nf = '0;
            if (ena) begin
                hist.push_back(m_s2);
                if (hist.size() > int'(STABLE)) void'(hist.pop_front());
                if (hist.size() == int'(STABLE)) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < hist.size(); j++)
                            if (hist[j][i] == m_db[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            nd[i] = ~m_db[i];
                            nr[i] = ~m_db[i];
                            nf[i] = m_db[i];
                        end
                    end
                end
            end
            m_db   <= nd;
            m_rise <= nr;
            m_fall <= nf;
            m_tog  <= m_tog ^ nr;
            m_s2   <= m_s1;
            m_s1   <= raw_in;
        end
    end

    always @(negedge clk) begin
        check("model_db", db_out, m_db);
        check("model_rise", rise_pulse, m_rise);
        check("model_fall", fall_pulse, m_fall);
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        check("model_tog", tog_out, m_tog);
`endif
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        raw_in = '0;
        ena    = 1'b1;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_db", db_out, 8'h00);
        check("rst_rise", rise_pulse, 8'h00);
        check("rst_fall", fall_pulse, 8'h00);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);

        // Clean press on bit 0: flips after edge k+5.
        raw_in = 8'h01;
        cycles(5);
        check("t1_db_early", db_out, 8'h00);
        cycles(1);
        check("t1_db", db_out, 8'h01);
        check("t1_rise", rise_pulse, 8'h01);
        check("t1_fall", fall_pulse, 8'h00);
        cycles(1);
        check("t1_rise_end", rise_pulse, 8'h00);

        // Three-cycle glitch is rejected and the count restarts from zero.
        raw_in = 8'h00;
        cycles(8);
        check("t2_setup", db_out, 8'h00);
        raw_in = 8'h01;
        cycles(3);
        raw_in = 8'h00;
        cycles(8);
        check("t2_glitch_db", db_out, 8'h00);
        raw_in = 8'h01;
        cycles(5);
        check("t2_full_latency_early", db_out, 8'h00);
        cycles(1);
        check("t2_full_latency_db", db_out, 8'h01);

        // All channels fall together.
        raw_in = 8'hFF;
        cycles(8);
        check("t3_setup", db_out, 8'hFF);
        raw_in = 8'h00;
        cycles(5);
        check("t3_db_early", db_out, 8'hFF);
        cycles(1);
        check("t3_db", db_out, 8'h00);
        check("t3_fall", fall_pulse, 8'hFF);
        check("t3_rise", rise_pulse, 8'h00);
        cycles(1);
        check("t3_fall_end", fall_pulse, 8'h00);

        // ena dropped after two counted cycles; two more needed afterwards.
        raw_in = 8'h03;
        cycles(4);
        ena = 1'b0;
        cycles(10);
        check("t4_frozen_db", db_out, 8'h00);
        check("t4_frozen_rise", rise_pulse, 8'h00);
        ena = 1'b1;
        cycles(1);
        check("t4_resume_early", db_out, 8'h00);
        cycles(1);
        check("t4_db", db_out, 8'h03);
        check("t4_rise", rise_pulse, 8'h03);

        // Asynchronous reset mid-count clears the held level immediately.
        raw_in = 8'h83;
        cycles(3);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async_db", db_out, 8'h00);
        check("t5_async_rise", rise_pulse, 8'h00);
        check("t5_async_fall", fall_pulse, 8'h00);
        #14 rst_n = 1'b1;
        cycles(6);
        check("t5_db_early", db_out, 8'h00);
        cycles(1);
        check("t5_db", db_out, 8'h83);
        check("t5_rise", rise_pulse, 8'h83);

        // Two press/release cycles on bit 2 from a fresh reset.
        raw_in = 8'h00;
        cycles(8);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(3);
        raw_in = 8'h04;
        cycles(8);
        check("t6_press1_db", db_out, 8'h04);
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        check("t6_tog_after_press1", tog_out, 8'h04);
`endif
        raw_in = 8'h00;
        cycles(8);
        raw_in = 8'h04;
        cycles(8);
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        check("t6_tog_after_press2", tog_out, 8'h00);
`endif
        raw_in = 8'h00;
        cycles(8);
        check("t6_release_db", db_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
